// File: rtl/riscv_chk_pkg.sv
// riscv_chk_pkg
// Shared definitions for the commit checker: FSM state encoding, the layout
// of one expected-trace entry and its width as a function of XLEN.
//
// Entry layout, MSB to LSB: {pc[XLEN-1:0], we, rd[4:0], wdata[XLEN-1:0]}
package riscv_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_PASS = 3'd2,
        ST_FAIL = 3'd3,
        ST_TMO  = 3'd4
    } chk_state_t;

    localparam int RD_W = 5;

    // Total entry width: pc + wdata + rd + we
    function automatic int entry_w(input int xlen);
        return 2 * xlen + RD_W + 1;
    endfunction

    // wdata sits at bit 0; the remaining fields are stacked above it
    function automatic int off_rd(input int xlen);
        return xlen;
    endfunction

    function automatic int off_we(input int xlen);
        return xlen + RD_W;
    endfunction

    function automatic int off_pc(input int xlen);
        return xlen + RD_W + 1;
    endfunction

endpackage

// File: rtl/trace_mem.sv
// trace_mem
// Expected-trace storage: DEPTH entries of W bits, synchronous write,
// asynchronous (combinational) read. No reset: contents survive rst so a
// trace can be loaded once and replayed across runs.
//
// Ports
//   clk    rising-edge clock
//   we     write strobe (already qualified by the caller)
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data, combinational from raddr
module trace_mem
    import riscv_chk_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W     = entry_w(32)
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/riscv_commit_checker.sv
// riscv_commit_checker
// Compares the retired-instruction stream of a core against a preloaded
// expected trace and reports pass, first-mismatch or commit timeout.
//
// Build option: CHECK_PC_EN -- when defined, a commit must also match the
// stored pc; when undefined, the pc field is stored but never compared.
//
// Ports
//   clk, rst (async, active-high)
//   start         one-cycle pulse, begins a run (ignored while busy)
//   num_exp       entries to check this run, clamped to DEPTH
//   exp_we/exp_addr/exp_data   trace load port, ignored while busy
//   commit_valid/_pc/_we/_rd/_wdata   retired-instruction stream
//   busy          run in progress
//   pass/fail/timeout   sticky terminal flags
//   err_index     index of the failing entry (mismatch or timeout)
//   commit_count  matched commits this run
//   cycle_count   cycles spent running, saturating
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | comparing commits against entry[idx], idle timer running
// PASS  | all num_exp entries matched
// FAIL  | a commit mismatched entry[err_index]
// TMO   | TIMEOUT consecutive cycles without a commit
module riscv_commit_checker
    import riscv_chk_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [$clog2(DEPTH):0]    num_exp,
    input  logic                      exp_we,
    input  logic [$clog2(DEPTH)-1:0]  exp_addr,
    input  logic [2*XLEN+5:0]         exp_data,
    input  logic                      commit_valid,
    input  logic [XLEN-1:0]           commit_pc,
    input  logic                      commit_we,
    input  logic [4:0]                commit_rd,
    input  logic [XLEN-1:0]           commit_wdata,
    output logic                      busy,
    output logic                      pass,
    output logic                      fail,
    output logic                      timeout,
    output logic [$clog2(DEPTH):0]    err_index,
    output logic [$clog2(DEPTH):0]    commit_count,
    output logic [31:0]               cycle_count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = entry_w(XLEN);
    localparam int OFF_RD  = off_rd(XLEN);
    localparam int OFF_WE  = off_we(XLEN);
    localparam int OFF_PC  = off_pc(XLEN);
    localparam int TW      = $clog2(TIMEOUT + 1);

    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    chk_state_t state;

    logic [CW-1:0]      idx;
    logic [CW-1:0]      num_reg;
    logic [CW-1:0]      num_eff;
    logic [TW-1:0]      idle_tmr;

    logic               mem_we;
    logic [ENTRY_W-1:0] entry;
    logic               ent_we;
    logic [RD_W-1:0]    ent_rd;
    logic [XLEN-1:0]    ent_wdata;
    logic [XLEN-1:0]    ent_pc;
    logic               pc_ok;
    logic               match;
    logic               last;

    // Loading the trace while a run reads it would make results depend on
    // write/read ordering, so writes during RUN are simply dropped.
    assign mem_we = exp_we & (state != ST_RUN);

    trace_mem #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_trace_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (exp_addr),
        .wdata (exp_data),
        .raddr (idx[AW-1:0]),
        .rdata (entry)
    );

    assign ent_wdata = entry[XLEN-1:0];
    assign ent_rd    = entry[OFF_RD +: RD_W];
    assign ent_we    = entry[OFF_WE];
    assign ent_pc    = entry[OFF_PC +: XLEN];

`ifdef CHECK_PC_EN
    assign pc_ok = (commit_pc == ent_pc);
`else
    // pc is carried in the trace for debug visibility only
    logic unused_pc;
    assign pc_ok     = 1'b1;
    assign unused_pc = &{1'b0, commit_pc, ent_pc};
`endif

    // rd/wdata only matter for instructions that write a register
    assign match = pc_ok
                 & (commit_we == ent_we)
                 & (~ent_we | ((commit_rd == ent_rd) & (commit_wdata == ent_wdata)));

    // num_reg is never zero in RUN (zero-length runs go straight to PASS)
    assign last    = (idx == (num_reg - ONE_C));
    assign num_eff = (num_exp > DEPTH_C) ? DEPTH_C : num_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx          <= '0;
            num_reg      <= '0;
            idle_tmr     <= '0;
            busy         <= 1'b0;
            pass         <= 1'b0;
            fail         <= 1'b0;
            timeout      <= 1'b0;
            err_index    <= '0;
            commit_count <= '0;
            cycle_count  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (cycle_count != 32'hFFFF_FFFF) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                    // A commit always wins over an expiring idle timer
                    if (commit_valid) begin
                        if (match) begin
                            commit_count <= commit_count + ONE_C;
                            idle_tmr     <= TMR_LOAD;
                            if (last) begin
                                state <= ST_PASS;
                                busy  <= 1'b0;
                                pass  <= 1'b1;
                            end else begin
                                idx <= idx + ONE_C;
                            end
                        end else begin
                            state     <= ST_FAIL;
                            busy      <= 1'b0;
                            fail      <= 1'b1;
                            err_index <= idx;
                        end
                    end else if (idle_tmr == '0) begin
                        state     <= ST_TMO;
                        busy      <= 1'b0;
                        timeout   <= 1'b1;
                        err_index <= idx;
                    end else begin
                        idle_tmr <= idle_tmr - TW'(1);
                    end
                end

                default: begin
                    // IDLE and the terminal states all behave the same:
                    // hold flags until the next start
                    if (start) begin
                        idx          <= '0;
                        num_reg      <= num_eff;
                        idle_tmr     <= TMR_LOAD;
                        fail         <= 1'b0;
                        timeout      <= 1'b0;
                        err_index    <= '0;
                        commit_count <= '0;
                        cycle_count  <= '0;
                        if (num_eff == '0) begin
                            state <= ST_PASS;
                            busy  <= 1'b0;
                            pass  <= 1'b1;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            pass  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_commit_checker.sv
// tb_riscv_commit_checker
// Scoreboard bench: each run's expected outcome is computed from a bench-side
// copy of the trace and the commit list, queued, then compared once the
// checker leaves RUN.
module tb_riscv_commit_checker;

    localparam int XLEN    = 32;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  num_exp;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic [69:0] exp_data;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_we;
    logic [4:0]  commit_rd;
    logic [31:0] commit_wdata;
    logic        busy;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [4:0]  err_index;
    logic [4:0]  commit_count;
    logic [31:0] cycle_count;

    riscv_commit_checker #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_exp      (num_exp),
        .exp_we       (exp_we),
        .exp_addr     (exp_addr),
        .exp_data     (exp_data),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_we    (commit_we),
        .commit_rd    (commit_rd),
        .commit_wdata (commit_wdata),
        .busy         (busy),
        .pass         (pass),
        .fail         (fail),
        .timeout      (timeout),
        .err_index    (err_index),
        .commit_count (commit_count),
        .cycle_count  (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wdata;
    } ent_t;

    typedef struct {
        ent_t f;
        int   gap;
    } cmt_t;

    typedef struct {
        logic        p;
        logic        f;
        logic        t;
        logic [4:0]  ei;
        logic [4:0]  cc;
        logic [31:0] cyc;
    } res_t;

    ent_t mem_m [DEPTH];
    cmt_t cq [$];
    res_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic we,
                                input logic [4:0] rd, input logic [31:0] wdata);
        ent_t e;
        e.pc = pc; e.we = we; e.rd = rd; e.wdata = wdata;
        return e;
    endfunction

    function automatic bit match_m(input ent_t e, input ent_t c);
        bit ok;
        ok = (e.we == c.we) && (!e.we || (e.rd == c.rd && e.wdata == c.wdata));
`ifdef CHECK_PC_EN
        ok = ok && (e.pc == c.pc);
`endif
        return ok;
    endfunction

    task automatic load(input int a, input ent_t e);
        @(negedge clk);
        exp_we   = 1'b1;
        exp_addr = 4'(a);
        exp_data = {e.pc, e.we, e.rd, e.wdata};
        mem_m[a] = e;
        @(negedge clk);
        exp_we   = 1'b0;
    endtask

    task automatic add_cmt(input ent_t e, input int gap);
        cmt_t c;
        c.f = e; c.gap = gap;
        cq.push_back(c);
    endtask

    // Reference outcome of a run, walked one RUN cycle at a time
    task automatic model(input int nexp);
        res_t r;
        int   n, idx, idle, cyc;
        bit   done;
        r = '{p: 1'b0, f: 1'b0, t: 1'b0, ei: 5'd0, cc: 5'd0, cyc: 32'd0};
        n = (nexp > DEPTH) ? DEPTH : nexp;
        idx = 0; idle = 0; cyc = 0; done = 1'b0;
        if (n == 0) begin
            r.p = 1'b1;
            done = 1'b1;
        end
        foreach (cq[k]) begin
            for (int g = 0; g < cq[k].gap && !done; g++) begin
                cyc++;
                if (idle == TIMEOUT - 1) begin
                    r.t = 1'b1; r.ei = 5'(idx); done = 1'b1;
                end else begin
                    idle++;
                end
            end
            if (!done) begin
                cyc++;
                if (match_m(mem_m[idx], cq[k].f)) begin
                    r.cc = r.cc + 5'd1;
                    idle = 0;
                    if (idx == n - 1) begin
                        r.p = 1'b1; done = 1'b1;
                    end else begin
                        idx++;
                    end
                end else begin
                    r.f = 1'b1; r.ei = 5'(idx); done = 1'b1;
                end
            end
        end
        while (!done) begin
            cyc++;
            if (idle == TIMEOUT - 1) begin
                r.t = 1'b1; r.ei = 5'(idx); done = 1'b1;
            end else begin
                idle++;
            end
        end
        r.cyc = 32'(cyc);
        sb.push_back(r);
    endtask

    // poke: on the first commit cycle also try a trace write and a
    // zero-length start, both of which must be ignored while running
    task automatic run(input string name, input int nexp, input bit poke);
        res_t e;
        model(nexp);
        @(negedge clk);
        start   = 1'b1;
        num_exp = 5'(nexp);
        @(negedge clk);
        start   = 1'b0;
        chk({name, ".busy_on"}, 32'(busy), 32'(nexp != 0));
        foreach (cq[k]) begin
            commit_valid = 1'b0;
            repeat (cq[k].gap) @(negedge clk);
            commit_valid = 1'b1;
            commit_pc    = cq[k].f.pc;
            commit_we    = cq[k].f.we;
            commit_rd    = cq[k].f.rd;
            commit_wdata = cq[k].f.wdata;
            if (poke && k == 0) begin
                exp_we   = 1'b1;
                exp_addr = 4'd1;
                exp_data = '1;
                start    = 1'b1;
                num_exp  = 5'd0;
            end
            @(negedge clk);
            commit_valid = 1'b0;
            exp_we       = 1'b0;
            start        = 1'b0;
        end
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        chk({name, ".busy_off"}, 32'(busy), 32'd0);
        e = sb.pop_front();
        chk({name, ".pass"},    32'(pass),         32'(e.p));
        chk({name, ".fail"},    32'(fail),         32'(e.f));
        chk({name, ".timeout"}, 32'(timeout),      32'(e.t));
        chk({name, ".err_idx"}, 32'(err_index),    32'(e.ei));
        chk({name, ".commits"}, 32'(commit_count), 32'(e.cc));
        chk({name, ".cycles"},  32'(cycle_count),  32'(e.cyc));
        cq.delete();
    endtask

    task automatic chk_zero(input string name);
        chk({name, ".busy"},    32'(busy),         32'd0);
        chk({name, ".pass"},    32'(pass),         32'd0);
        chk({name, ".fail"},    32'(fail),         32'd0);
        chk({name, ".timeout"}, 32'(timeout),      32'd0);
        chk({name, ".err_idx"}, 32'(err_index),    32'd0);
        chk({name, ".commits"}, 32'(commit_count), 32'd0);
        chk({name, ".cycles"},  cycle_count,       32'd0);
    endtask

    task automatic load_base();
        load(0, mk(32'h0, 1'b1, 5'd3, 32'hFFFF_FFFE));  // sub x3
        load(1, mk(32'h4, 1'b1, 5'd4, 32'h0000_0001));  // slt x4
        load(2, mk(32'h8, 1'b0, 5'd0, 32'h0000_0000));  // beq
    endtask

    initial begin
        ent_t c;
        rst = 1'b1; start = 1'b0; num_exp = '0;
        exp_we = 1'b0; exp_addr = '0; exp_data = '0;
        commit_valid = 1'b0; commit_pc = '0; commit_we = 1'b0;
        commit_rd = '0; commit_wdata = '0;
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        load_base();

        // three matching commits
        for (int i = 0; i < 3; i++) add_cmt(mem_m[i], 0);
        run("match3", 3, 1'b0);

        // second commit carries the wrong result
        add_cmt(mem_m[0], 0);
        c = mem_m[1]; c.wdata = 32'h0; add_cmt(c, 0);
        add_cmt(mem_m[2], 0);
        run("mism1", 3, 1'b0);

        // no commits at all
        run("tmo_idle", 3, 1'b0);

        // commit lands on the last allowed idle cycle
        add_cmt(mem_m[0], TIMEOUT - 1);
        add_cmt(mem_m[1], 0);
        add_cmt(mem_m[2], 0);
        run("edge_ok", 3, 1'b0);

        // one cycle too late
        add_cmt(mem_m[0], TIMEOUT);
        run("edge_tmo", 3, 1'b0);

        // non-writing entry: rd/wdata are don't-care
        add_cmt(mem_m[0], 2);
        add_cmt(mem_m[1], 1);
        c = mem_m[2]; c.rd = 5'd7; c.wdata = 32'h55; add_cmt(c, 0);
        run("nowb_dc", 3, 1'b0);

        // we disagrees on the third entry
        add_cmt(mem_m[0], 0);
        add_cmt(mem_m[1], 0);
        c = mem_m[2]; c.we = 1'b1; add_cmt(c, 0);
        run("we_mism", 3, 1'b0);

        // trace write and start during RUN both ignored
        for (int i = 0; i < 3; i++) add_cmt(mem_m[i], 0);
        run("poke", 3, 1'b1);

        // zero-length run
        run("zero", 0, 1'b0);

        // full trace, num_exp clamped down to DEPTH
        for (int i = 0; i < DEPTH; i++)
            load(i, mk($urandom, 1'($urandom), 5'($urandom), $urandom));
        for (int i = 0; i < DEPTH; i++) add_cmt(mem_m[i], i % 3);
        run("clamp", 31, 1'b0);

        // pc differs, data equal
        load(0, mk(32'h4, 1'b1, 5'd1, 32'h1234));
        add_cmt(mk(32'h8, 1'b1, 5'd1, 32'h1234), 0);
        run("pc_diff", 1, 1'b0);

        // reset mid-run, then rerun from index 0 with the trace intact
        load_base();
        @(negedge clk);
        start = 1'b1; num_exp = 5'd3;
        @(negedge clk);
        start = 1'b0;
        commit_valid = 1'b1; commit_pc = mem_m[0].pc; commit_we = mem_m[0].we;
        commit_rd = mem_m[0].rd; commit_wdata = mem_m[0].wdata;
        @(negedge clk);
        commit_valid = 1'b0;
        chk("abort.pre_commits", 32'(commit_count), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) add_cmt(mem_m[i], 0);
        run("rerun", 3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
